keccak_msg_arbiter: RTL

- Shares one keccak hash core (32-bit word in, 512-bit digest out) between NREQ independent message sources.
- Grants the core to one requester at a time, round-robin, and pulses the core's reset before each message.
- Forwards the requester's words under core back-pressure (buffer_full), waits for out_ready, then returns the captured digest with a per-requester done strobe.
- Sits between the message producers and the single keccak instance.

---
 rtl/keccak_arb_pkg.sv | 17 +
 rtl/keccak_rr_pick.sv | 37 +++
 rtl/keccak_msg_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/keccak_arb_pkg.sv
// Shared types and widths for the keccak message arbiter.
// Optional build macro: KECCAK_ARB_TIMEOUT_EN (enables the WAIT watchdog in the top).
package keccak_arb_pkg;

  localparam int WORD_W     = 32;
  localparam int DIGEST_W   = 512;
  localparam int BYTE_NUM_W = 2;

  // Arbiter FSM: pick owner, clear core, stream words, wait for digest.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_FEED = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Returns the winner one-hot plus its index; pick_any is low when no request is set.
module keccak_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  localparam logic [IDX_W:0] NREQ_V = (IDX_W+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IDX_W:0]  sum;

  // Rotate requests so bit 0 is the pointer lane; scanning downward leaves the lowest offset winning.
  always_comb begin
    rot      = NREQ'({req, req} >> ptr);
    pick_any = 1'b0;
    sum      = {1'b0, ptr};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick_any = 1'b1;
        sum      = {1'b0, ptr} + (IDX_W+1)'(i);
      end
    end
    if (sum >= NREQ_V) begin
      sum = sum - NREQ_V;
    end
    pick_idx = sum[IDX_W-1:0];
    pick_oh  = pick_any ? (NREQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/keccak_msg_arbiter.sv
// Round-robin arbiter sharing one keccak core between NREQ message sources.
// Each message: pick owner (IDLE), pulse core reset (CLR), stream words (FEED),
// wait for the digest (WAIT), then return it with a one-cycle dig_valid to the owner.
// Handshake: a word on lane g moves when req_valid[g]=1 and core_buffer_full=0 in FEED;
// that same cycle req_accept[g] and core_in_ready are high, and the source must advance.
// Optional build macro: KECCAK_ARB_TIMEOUT_EN adds a WAIT watchdog and the dig_err output.
module keccak_msg_arbiter
  import keccak_arb_pkg::*;
#(
  parameter int NREQ = 2
`ifdef KECCAK_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [WORD_W*NREQ-1:0]     req_data,
  input  logic [NREQ-1:0]            req_last,
  input  logic [BYTE_NUM_W*NREQ-1:0] req_byte_num,
  output logic [NREQ-1:0]            req_accept,
  output logic [NREQ-1:0]            grant,
  output logic [DIGEST_W-1:0]        dig_data,
  output logic [NREQ-1:0]            dig_valid,
`ifdef KECCAK_ARB_TIMEOUT_EN
  output logic                       dig_err,
`endif
  output logic                       core_reset,
  output logic [WORD_W-1:0]          core_in,
  output logic                       core_in_ready,
  output logic                       core_is_last,
  output logic [BYTE_NUM_W-1:0]      core_byte_num,
  input  logic                       core_buffer_full,
  input  logic [DIGEST_W-1:0]        core_out,
  input  logic                       core_out_ready,
  output arb_state_t                 dbg_state
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t             state_q, state_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [DIGEST_W-1:0]    dig_data_q, dig_data_d;
  logic [NREQ-1:0]        dig_valid_q, dig_valid_d;

  logic [NREQ-1:0]        pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   lane_valid;
  logic                   lane_last;
  logic [WORD_W-1:0]      lane_data;
  logic [BYTE_NUM_W-1:0]  lane_bn;
  logic                   xfer;
  logic                   wait_done;
  logic [IDX_W-1:0]       next_ptr;

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dig_err_q, dig_err_d;
  logic                   timeout_hit;
`endif

  keccak_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Select the owner's lane; only meaningful while a grant is held.
  always_comb begin
    lane_valid = 1'b0;
    lane_last  = 1'b0;
    lane_data  = '0;
    lane_bn    = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gidx_q == IDX_W'(r)) begin
        lane_valid = req_valid[r];
        lane_last  = req_last[r];
        lane_data  = req_data[r*WORD_W +: WORD_W];
        lane_bn    = req_byte_num[r*BYTE_NUM_W +: BYTE_NUM_W];
      end
    end
  end

  // Transfer qualifier, message-complete condition and the pointer past the owner.
  always_comb begin
    xfer     = (state_q == ST_FEED) && lane_valid && !core_buffer_full;
    next_ptr = (gidx_q == IDX_W'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
`ifdef KECCAK_ARB_TIMEOUT_EN
    timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    wait_done   = core_out_ready || timeout_hit;
`else
    wait_done   = core_out_ready;
`endif
  end

  // State and datapath registers; async reset returns to IDLE and drops any partial message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      dig_data_q  <= '0;
      dig_valid_q <= '0;
`ifdef KECCAK_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      dig_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      dig_data_q  <= dig_data_d;
      dig_valid_q <= dig_valid_d;
`ifdef KECCAK_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      dig_err_q   <= dig_err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any)          state_d = ST_CLR;
      ST_CLR:                         state_d = ST_FEED;
      ST_FEED: if (xfer && lane_last) state_d = ST_WAIT;
      ST_WAIT: if (wait_done)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Registered datapath: latch winner in IDLE, capture digest and release grant at end of WAIT.
  always_comb begin
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    dig_data_d  = dig_data_q;
    dig_valid_d = '0;
`ifdef KECCAK_ARB_TIMEOUT_EN
    cnt_d       = '0;
    dig_err_d   = 1'b0;
`endif
    if (state_q == ST_IDLE && pick_any) begin
      grant_d = pick_oh;
      gidx_d  = pick_idx;
    end
    if (state_q == ST_WAIT) begin
`ifdef KECCAK_ARB_TIMEOUT_EN
      cnt_d = cnt_q + 1'b1;
`endif
      if (wait_done) begin
        grant_d     = '0;
        ptr_d       = next_ptr;
        dig_valid_d = grant_q;
        if (core_out_ready) begin
          dig_data_d = core_out;
        end
`ifdef KECCAK_ARB_TIMEOUT_EN
        else begin
          dig_err_d = 1'b1;
        end
`endif
      end
    end
  end

  // Outputs: core strobe and lane mux are combinational on the transfer; the rest is registered.
  always_comb begin
    req_accept    = xfer ? grant_q : '0;
    core_in_ready = xfer;
    core_in       = xfer ? lane_data : '0;
    core_is_last  = xfer && lane_last;
    core_byte_num = xfer ? lane_bn : '0;
    core_reset    = reset || (state_q == ST_CLR);
    grant         = grant_q;
    dig_data      = dig_data_q;
    dig_valid     = dig_valid_q;
    dbg_state     = state_q;
`ifdef KECCAK_ARB_TIMEOUT_EN
    dig_err       = dig_err_q;
`endif
  end

endmodule
